// File: rtl/fcmp_pkg.sv
// fcmp_pkg: shared types and helpers for the single-precision compare pipeline.
package fcmp_pkg;

  typedef enum logic [1:0] {
    CMP_FEQ    = 2'b00,
    CMP_FLT    = 2'b01,
    CMP_FLE    = 2'b10,
    CMP_FUNORD = 2'b11
  } cmp_op_e;

  typedef struct packed {
    logic result;
    logic nv;
    logic unord;
  } cmp_res_t;

  localparam logic [7:0] EXP_ALL1 = 8'hFF;

  // Any NaN: exponent all ones with a non-zero fraction.
  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == EXP_ALL1) && (f[22:0] != 23'd0);
  endfunction

  // Signalling NaN: a NaN whose quiet bit (frac[22]) is clear.
  function automatic logic is_snan(input logic [31:0] f);
    return is_nan(f) && (f[22] == 1'b0);
  endfunction

  // Predicate and invalid-flag selection from the fcmp relation outputs.
  // Ordered relations are forced low whenever the pair is unordered.
  function automatic cmp_res_t cmp_select(input cmp_op_e op, input logic blta,
                                          input logic aeqb, input logic unord,
                                          input logic [31:0] opa, input logic [31:0] opb);
    cmp_res_t r;
    r       = '0;
    r.unord = unord;
    case (op)
      CMP_FEQ: begin
        r.result = aeqb & ~unord;
        r.nv     = is_snan(opa) | is_snan(opb);
      end
      CMP_FLT: begin
        r.result = blta & ~unord;
        r.nv     = is_nan(opa) | is_nan(opb);
      end
      CMP_FLE: begin
        r.result = (blta | aeqb) & ~unord;
        r.nv     = is_nan(opa) | is_nan(opb);
      end
      CMP_FUNORD: begin
        r.result = unord;
        r.nv     = 1'b0;
      end
      default: begin
        r.result = 1'b0;
        r.nv     = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fcmp.sv
// fcmp: combinational IEEE-754 single-precision magnitude/sign comparator.
// Naming is historical: altb=1 means A>B, blta=1 means A<B.
module fcmp
  import fcmp_pkg::*;
(
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic        altb_o,
  output logic        blta_o,
  output logic        aeqb_o,
  output logic        unordered_o
);

  logic [30:0] mag_a_s;
  logic [30:0] mag_b_s;
  logic        all_zero_s;
  logic [2:0]  rel_s;

  // Sign/magnitude ordering; +0 and -0 are treated as equal via all_zero.
  always_comb begin
    mag_a_s     = opa_i[30:0];
    mag_b_s     = opb_i[30:0];
    all_zero_s  = (mag_a_s == 31'd0) && (mag_b_s == 31'd0);
    unordered_o = is_nan(opa_i) | is_nan(opb_i);
    case ({opa_i[31], opb_i[31]})
      2'b00:   rel_s = {mag_a_s > mag_b_s, mag_a_s < mag_b_s, mag_a_s == mag_b_s};
      2'b01:   rel_s = {~all_zero_s, 1'b0, all_zero_s};
      2'b10:   rel_s = {1'b0, ~all_zero_s, all_zero_s};
      2'b11:   rel_s = {mag_a_s < mag_b_s, mag_a_s > mag_b_s, mag_a_s == mag_b_s};
      default: rel_s = 3'bxxx;
    endcase
    altb_o = rel_s[2] & ~unordered_o;
    blta_o = rel_s[1] & ~unordered_o;
    aeqb_o = rel_s[0] & ~unordered_o;
  end

endmodule

// File: rtl/fcmp_pipe_chk.sv
// fcmp_pipe_chk: protocol checker for the fcmp_pipe result interface.
module fcmp_pipe_chk #(
  parameter int TAG_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic             out_valid,
  input logic             out_ready,
  input logic             out_result,
  input logic             out_nv,
  input logic [TAG_W-1:0] out_tag
);

  // A stalled result must hold every field until it is accepted.
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_result) && $stable(out_nv)
                                   && $stable(out_tag)));

  // A presented result never carries unknown bits.
  a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> !$isunknown({out_result, out_nv, out_tag}));

endmodule

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage valid/ready compare pipeline. S1 registers the request,
// fcmp plus predicate selection sit between S1 and S2, S2 holds the result.
// Sticky NV and a saturating unordered counter update on result handoff.
module fcmp_pipe
  import fcmp_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_opa,
  input  logic [31:0]      in_opb,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic             out_nv,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flags_clr,
  output logic             sticky_nv,
  output logic [CNT_W-1:0] unord_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_opa_q, s1_opb_q;
  cmp_op_e          s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q, s2_valid_d;
  cmp_res_t         s2_res_q, s2_res_d;
  logic [TAG_W-1:0] s2_tag_q;

  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic s2_adv_s, in_ready_s, in_fire_s, out_fire_s;
  // A>B is not needed by any supported predicate.
  logic altb_unused_s;
  logic blta_s, aeqb_s, unord_s;

  fcmp u_fcmp (
    .opa_i       (s1_opa_q),
    .opb_i       (s1_opb_q),
    .altb_o      (altb_unused_s),
    .blta_o      (blta_s),
    .aeqb_o      (aeqb_s),
    .unordered_o (unord_s)
  );

  // Stage advance and handshake decisions; S1 refills in the same cycle it drains.
  always_comb begin
    s2_adv_s   = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready_s = ~s1_valid_q | s2_adv_s;
    in_fire_s  = in_valid & in_ready_s;
    out_fire_s = s2_valid_q & out_ready;
  end

  // Next-state of both stage valid bits and the S2 result payload.
  always_comb begin
    s2_res_d = cmp_select(s1_op_q, blta_s, aeqb_s, unord_s, s1_opa_q, s1_opb_q);
    if (in_fire_s) begin
      s1_valid_d = 1'b1;
    end else if (s2_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_adv_s) begin
      s2_valid_d = 1'b1;
    end else if (out_fire_s) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Sticky NV and saturating unordered count; a clear overrides a same-cycle handoff.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (flags_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (out_fire_s) begin
      sticky_d = sticky_q | s2_res_q.nv;
      if (s2_res_q.unord && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
    end
  end

  // Pipeline and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_opa_q   <= 32'd0;
      s1_opb_q   <= 32'd0;
      s1_op_q    <= CMP_FEQ;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_tag_q   <= '0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
      if (in_fire_s) begin
        s1_opa_q <= in_opa;
        s1_opb_q <= in_opb;
        s1_op_q  <= cmp_op_e'(in_op);
        s1_tag_q <= in_tag;
      end
      if (s2_adv_s) begin
        s2_res_q <= s2_res_d;
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = s2_valid_q;
  assign out_result = s2_res_q.result;
  assign out_nv     = s2_res_q.nv;
  assign out_tag    = s2_tag_q;
  assign sticky_nv  = sticky_q;
  assign unord_cnt  = cnt_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// tb_fcmp_pipe: directed and randomized checks of fcmp_pipe against a value-level model.
module tb_fcmp_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_result, out_nv;
  logic [31:0] in_opa, in_opb;
  logic [1:0]  in_op;
  logic [3:0]  in_tag, out_tag;
  logic        flags_clr, sticky_nv;
  logic [7:0]  unord_cnt;
  logic        in_ready2, out_valid2, out_result2, out_nv2, sticky_nv2;
  logic [3:0]  out_tag2;
  logic [1:0]  unord_cnt2;

  int checks = 0;
  int errors = 0;
  bit m_sticky = 1'b0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  fcmp_pipe #(.TAG_W(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opa(in_opa), .in_opb(in_opb), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_nv(out_nv), .out_tag(out_tag), .flags_clr(flags_clr),
    .sticky_nv(sticky_nv), .unord_cnt(unord_cnt));

  fcmp_pipe #(.TAG_W(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_opa(in_opa), .in_opb(in_opb), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
    .out_nv(out_nv2), .out_tag(out_tag2), .flags_clr(flags_clr),
    .sticky_nv(sticky_nv2), .unord_cnt(unord_cnt2));

  fcmp_pipe_chk #(.TAG_W(4)) u_chk (
    .clk(clk), .rst_n(rst_n), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_nv(out_nv), .out_tag(out_tag));

  // ---------------- reference model (numeric value ordering) ----------------
  function automatic logic f_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  // Signed integer key that orders finite/infinite floats by value; +0 == -0.
  function automatic longint fkey(input logic [31:0] f);
    longint m;
    m = longint'(f[30:0]);
    return f[31] ? -m : m;
  endfunction

  // Returns {result, nv, unordered}.
  function automatic logic [2:0] ref_cmp(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic un, sn, lt, eq;
    un = f_nan(a) | f_nan(b);
    sn = (f_nan(a) && !a[22]) || (f_nan(b) && !b[22]);
    lt = !un && (fkey(a) < fkey(b));
    eq = !un && (fkey(a) == fkey(b));
    case (op)
      2'd0:    return {eq, sn, un};
      2'd1:    return {lt, un, un};
      2'd2:    return {lt | eq, un, un};
      default: return {un, 1'b0, un};
    endcase
  endfunction

  function automatic logic [31:0] rand_fp(input logic [31:0] other);
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       r = {r[31], 31'd0};
      1:       r = {r[31], 8'hFF, 23'd0};
      2:       r = {r[31], 8'hFF, 1'b1, r[21:0]};
      3:       r = {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
      4:       r = other;
      5:       r = {~other[31], other[30:0]};
      6:       r = {r[31], 8'd127, r[22:0]};
      default: r = $urandom;
    endcase
    return r;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op into an empty pipe and hold out_ready high; returns the
  // presented result and the cycles from handshake to out_valid.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input bit clr, output logic res,
                       output logic nv, output logic [3:0] otag, output int lat);
    in_valid = 1'b1; in_op = op; in_opa = a; in_opb = b; in_tag = tag;
    out_ready = 1'b1; flags_clr = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 20);
    res = out_result; nv = out_nv; otag = out_tag;
    flags_clr = clr;
    tick();
    flags_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flags_clr = 1'b0;
    in_opa = 32'd0; in_opb = 32'd0; in_op = 2'd0; in_tag = 4'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({out_result, out_nv, out_tag} !== 6'd0) begin errors++; $display("FAIL reset_out_fields got %b%b%h want 0", out_result, out_nv, out_tag); end
    checks++; if ({sticky_nv, unord_cnt, unord_cnt2} !== 11'd0) begin errors++; $display("FAIL reset_status got %b %0d %0d want 0", sticky_nv, unord_cnt, unord_cnt2); end
    m_sticky = 1'b0; m_cnt = 0;
  endtask

  task automatic test_flt_basic();
    logic r, n; logic [3:0] t; int lat;
    do_op(2'd1, 32'h3F800000, 32'h40000000, 4'd5, 1'b0, r, n, t, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL flt_latency got %0d want 2", lat); end
    checks++; if ({r, n} !== 2'b10) begin errors++; $display("FAIL flt_1_lt_2 got r=%b nv=%b want r=1 nv=0", r, n); end
    checks++; if (t !== 4'd5) begin errors++; $display("FAIL flt_tag got %h want 5", t); end
  endtask

  task automatic test_signed_zero();
    logic r, n; logic [3:0] t; int lat;
    do_op(2'd0, 32'h00000000, 32'h80000000, 4'd6, 1'b0, r, n, t, lat);
    checks++; if ({r, n} !== 2'b10) begin errors++; $display("FAIL feq_pm_zero got r=%b nv=%b want r=1 nv=0", r, n); end
    do_op(2'd2, 32'h00000000, 32'h80000000, 4'd7, 1'b0, r, n, t, lat);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL fle_pm_zero got %b want 1", r); end
  endtask

  task automatic test_nan();
    logic r, n; logic [3:0] t; int lat;
    do_op(2'd0, 32'h7FA00000, 32'h3F800000, 4'd8, 1'b0, r, n, t, lat);
    checks++; if ({r, n} !== 2'b01) begin errors++; $display("FAIL feq_snan got r=%b nv=%b want r=0 nv=1", r, n); end
    checks++; if ({sticky_nv, unord_cnt} !== 9'h101) begin errors++; $display("FAIL snan_status got sticky=%b cnt=%0d want 1 1", sticky_nv, unord_cnt); end
    do_op(2'd0, 32'h7FC00000, 32'h3F800000, 4'd9, 1'b0, r, n, t, lat);
    checks++; if ({r, n} !== 2'b00) begin errors++; $display("FAIL feq_qnan got r=%b nv=%b want 0 0", r, n); end
    do_op(2'd1, 32'h7FC00000, 32'h3F800000, 4'd10, 1'b0, r, n, t, lat);
    checks++; if ({r, n} !== 2'b01) begin errors++; $display("FAIL flt_qnan got r=%b nv=%b want r=0 nv=1", r, n); end
    m_sticky = 1'b1; m_cnt = 3;
    checks++; if (unord_cnt2 !== 2'd3) begin errors++; $display("FAIL cnt2_after_nan got %0d want 3", unord_cnt2); end
  endtask

  // Stream n ops; rnd=0 gives back-to-back input with out_ready low in cycles 3..6.
  task automatic test_stream(input int n, input bit rnd);
    logic [6:0]  q[$];
    logic [6:0]  e;
    logic [6:0]  prev_out;
    logic [31:0] a, b;
    logic [1:0]  op;
    int sent, recv, t;
    bit saw_drop, prev_stall;
    sent = 0; recv = 0; t = 0; saw_drop = 1'b0; prev_stall = 1'b0; prev_out = '0;
    op = 2'($urandom_range(0, 3)); a = rand_fp(32'h3F800000); b = rand_fp(a);
    while (recv < n && t < 20 * n + 100) begin
      in_valid = (sent < n) && (!rnd || ($urandom_range(0, 3) != 0));
      in_op = op; in_opa = a; in_opb = b; in_tag = sent[3:0];
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(t >= 3 && t <= 6);
      #1;
      if (prev_stall) begin
        checks++; if ({out_valid, out_result, out_nv, out_tag} !== prev_out) begin errors++; $display("FAIL stall_stable got %b want %b", {out_valid, out_result, out_nv, out_tag}, prev_out); end
      end
      if (in_valid && !in_ready) saw_drop = 1'b1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL stream_extra got tag %h want none", out_tag); end
        else begin
          e = q.pop_front();
          checks++; if ({out_tag, out_result, out_nv} !== e[6:1]) begin errors++; $display("FAIL stream_result got tag=%h r=%b nv=%b want tag=%h r=%b nv=%b", out_tag, out_result, out_nv, e[6:3], e[2], e[1]); end
          m_sticky = m_sticky | e[1];
          m_cnt = m_cnt + int'(e[0]);
        end
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out = {out_valid, out_result, out_nv, out_tag};
      if (in_valid && in_ready) begin
        q.push_back({sent[3:0], ref_cmp(op, a, b)});
        sent++;
        op = 2'($urandom_range(0, 3)); a = rand_fp(b); b = rand_fp(a);
      end
      tick();
      t++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (recv != n || sent != n) begin errors++; $display("FAIL stream_count got sent=%0d recv=%0d want %0d", sent, recv, n); end
    checks++; if (!saw_drop) begin errors++; $display("FAIL stream_in_ready_drop got never want dropped"); end
    repeat (3) begin
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_duplicate got out_valid=%b want 0", out_valid); end
      tick();
    end
    checks++; if (sticky_nv !== m_sticky) begin errors++; $display("FAIL stream_sticky got %b want %b", sticky_nv, m_sticky); end
    checks++; if (int'(unord_cnt) != sat(m_cnt, 255)) begin errors++; $display("FAIL stream_cnt got %0d want %0d", unord_cnt, sat(m_cnt, 255)); end
    checks++; if (int'(unord_cnt2) != sat(m_cnt, 3)) begin errors++; $display("FAIL stream_cnt2 got %0d want %0d", unord_cnt2, sat(m_cnt, 3)); end
  endtask

  task automatic test_saturate_clear();
    logic r, n; logic [3:0] t; int lat;
    checks++; if (sticky_nv !== m_sticky) begin errors++; $display("FAIL pre_clear_sticky got %b want %b", sticky_nv, m_sticky); end
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    m_sticky = 1'b0; m_cnt = 0;
    checks++; if ({sticky_nv, unord_cnt} !== 9'd0) begin errors++; $display("FAIL clear_idle got sticky=%b cnt=%0d want 0 0", sticky_nv, unord_cnt); end
    for (int i = 0; i < 5; i++) begin
      do_op(2'd3, 32'h7FC00000, 32'h3F800000, 4'(i), 1'b0, r, n, t, lat);
      checks++; if ({r, n} !== 2'b10) begin errors++; $display("FAIL funord_qnan got r=%b nv=%b want 1 0", r, n); end
    end
    checks++; if (unord_cnt2 !== 2'd3) begin errors++; $display("FAIL cnt2_saturate got %0d want 3", unord_cnt2); end
    checks++; if (unord_cnt !== 8'd5) begin errors++; $display("FAIL cnt8_five got %0d want 5", unord_cnt); end
    do_op(2'd1, 32'h7FC00000, 32'h3F800000, 4'd6, 1'b1, r, n, t, lat);
    checks++; if ({r, n} !== 2'b01) begin errors++; $display("FAIL flt_qnan_clr got r=%b nv=%b want 0 1", r, n); end
    checks++; if ({sticky_nv, unord_cnt, unord_cnt2} !== 11'd0) begin errors++; $display("FAIL clear_wins got sticky=%b cnt=%0d cnt2=%0d want 0", sticky_nv, unord_cnt, unord_cnt2); end
  endtask

  task automatic test_reset_midflight();
    bit saw;
    out_ready = 1'b0; in_valid = 1'b1;
    in_op = 2'd1; in_opa = 32'h3F800000; in_opb = 32'h40000000; in_tag = 4'hA;
    tick();
    in_tag = 4'hB;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL full_before_reset got valid=%b ready=%b want 1 0", out_valid, in_ready); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_sticky = 1'b0; m_cnt = 0;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL after_reset got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    out_ready = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid !== 1'b0) saw = 1'b1;
    end
    checks++; if (saw) begin errors++; $display("FAIL stale_result got out_valid=1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_flt_basic();
    test_signed_zero();
    test_nan();
    test_stream(10, 1'b0);
    test_saturate_clear();
    test_stream(150, 1'b1);
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
